// File: rtl/display_pkg.sv
// Shared constants for the display adaptor: counter widths and active-image geometry.
`default_nettype none

package display_pkg;

  localparam int PX_W   = 10;
  localparam int LINE_W = 10;
  localparam int ADDR_W = 14;

  localparam int ACTIVE_PX    = 10;
  localparam int ACTIVE_LINES = 10;
  localparam int VBLANK_LINES = 2;

endpackage

`default_nettype wire

// File: rtl/scan_counter.sv
// Generic wrapping up-counter with synchronous clear (priority) and level increment.
`default_nettype none

module scan_counter #(
  parameter int W   = 10,
  parameter int MAX = 1023
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = W'(1);

  logic [W-1:0] r_count;
  logic [W-1:0] w_next_inc;

  // A limit at or beyond the full range is just the natural binary rollover.
  generate
    if (longint'(MAX) >= ((longint'(1) << W) - 1)) begin : g_natural
      assign w_next_inc = r_count + ONE;
    end else begin : g_limit
      localparam logic [W-1:0] MAX_V = W'(MAX);
      assign w_next_inc = (r_count == MAX_V) ? '0 : (r_count + ONE);
    end
  endgenerate

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc) begin
      r_count <= w_next_inc;
    end
  end

  assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/display_scan_counters.sv
// Pixel, line and two frame-buffer address counters for the display adaptor controller.
`default_nettype none

module display_scan_counters
  import display_pkg::*;
#(
  parameter int PX_W     = display_pkg::PX_W,
  parameter int LINE_W   = display_pkg::LINE_W,
  parameter int ADDR_W   = display_pkg::ADDR_W,
  parameter int PX_MAX   = 1023,
  parameter int LINE_MAX = 1023,
  parameter int ADDR_MAX = 16383
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ResetPx,
  input  logic              IncPx,
  input  logic              ResetLine,
  input  logic              IncLine,
  input  logic              ResetAddr0,
  input  logic              IncAddr0,
  input  logic              ResetAddr1,
  input  logic              IncAddr1,
  output logic [PX_W-1:0]   PxOut,
  output logic [LINE_W-1:0] LineOut,
  output logic [ADDR_W-1:0] Addr0,
  output logic [ADDR_W-1:0] Addr1
);

  scan_counter #(.W(PX_W), .MAX(PX_MAX)) u_px (
    .clock (clock),
    .reset (reset),
    .clr   (ResetPx),
    .inc   (IncPx),
    .count (PxOut)
  );

  scan_counter #(.W(LINE_W), .MAX(LINE_MAX)) u_line (
    .clock (clock),
    .reset (reset),
    .clr   (ResetLine),
    .inc   (IncLine),
    .count (LineOut)
  );

  scan_counter #(.W(ADDR_W), .MAX(ADDR_MAX)) u_addr0 (
    .clock (clock),
    .reset (reset),
    .clr   (ResetAddr0),
    .inc   (IncAddr0),
    .count (Addr0)
  );

  scan_counter #(.W(ADDR_W), .MAX(ADDR_MAX)) u_addr1 (
    .clock (clock),
    .reset (reset),
    .clr   (ResetAddr1),
    .inc   (IncAddr1),
    .count (Addr1)
  );

endmodule

`default_nettype wire

// File: tb/tb_display_scan_counters.sv
// Directed self-checking bench for display_scan_counters, with a second instance using PX_MAX=9.
`default_nettype none

module tb_display_scan_counters;

  logic clock = 1'b0;
  logic reset;
  logic ResetPx, IncPx, ResetLine, IncLine;
  logic ResetAddr0, IncAddr0, ResetAddr1, IncAddr1;

  logic [9:0]  PxOut, LineOut;
  logic [13:0] Addr0, Addr1;
  logic [9:0]  w_px9, w_line9;
  logic [13:0] w_addr0_9, w_addr1_9;

  int err_cnt = 0;
  int chk_cnt = 0;

  always #5 clock = ~clock;

  display_scan_counters u_dut (
    .clock(clock), .reset(reset),
    .ResetPx(ResetPx), .IncPx(IncPx), .ResetLine(ResetLine), .IncLine(IncLine),
    .ResetAddr0(ResetAddr0), .IncAddr0(IncAddr0), .ResetAddr1(ResetAddr1), .IncAddr1(IncAddr1),
    .PxOut(PxOut), .LineOut(LineOut), .Addr0(Addr0), .Addr1(Addr1)
  );

  display_scan_counters #(.PX_MAX(9)) u_dut_wrap (
    .clock(clock), .reset(reset),
    .ResetPx(ResetPx), .IncPx(IncPx), .ResetLine(ResetLine), .IncLine(IncLine),
    .ResetAddr0(ResetAddr0), .IncAddr0(IncAddr0), .ResetAddr1(ResetAddr1), .IncAddr1(IncAddr1),
    .PxOut(w_px9), .LineOut(w_line9), .Addr0(w_addr0_9), .Addr1(w_addr1_9)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobes_off();
    ResetPx = 0; IncPx = 0; ResetLine = 0; IncLine = 0;
    ResetAddr0 = 0; IncAddr0 = 0; ResetAddr1 = 0; IncAddr1 = 0;
  endtask

  task automatic strobes_rand();
    {ResetPx, IncPx, ResetLine, IncLine} = 4'($urandom);
    {ResetAddr0, IncAddr0, ResetAddr1, IncAddr1} = 4'($urandom);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_px"},   32'(PxOut),   32'd0);
    check({tag, "_line"}, 32'(LineOut), 32'd0);
    check({tag, "_a0"},   32'(Addr0),   32'd0);
    check({tag, "_a1"},   32'(Addr1),   32'd0);
  endtask

  initial begin
    reset = 1'b0;
    strobes_off();
    #2;
    check_all_zero("por");
    step();
    step();
    check_all_zero("por_hold");
    reset = 1'b1;
    step();
    step();
    check_all_zero("rel_idle");

    // Pixel counting and clear priority
    IncPx = 1;
    for (int i = 1; i <= 10; i++) begin
      step();
      check("px_step", 32'(PxOut), 32'(i));
      check("px9_step", 32'(w_px9), 32'(i % 10));
    end
    ResetPx = 1;
    step();
    check("px_clr_prio", 32'(PxOut), 32'd0);
    check("px9_clr_prio", 32'(w_px9), 32'd0);
    ResetPx = 0;

    // Wrap at PX_MAX=9
    for (int i = 1; i <= 12; i++) begin
      step();
      check("px9_wrap", 32'(w_px9), 32'(i % 10));
    end
    check("px_nowrap", 32'(PxOut), 32'd12);
    IncPx = 0;
    ResetPx = 1;
    step();
    ResetPx = 0;

    // Line/pixel independence
    IncPx = 1;
    repeat (9) step();
    IncPx = 0;
    IncLine = 1;
    step();
    IncLine = 0;
    check("indep_line", 32'(LineOut), 32'd1);
    check("indep_px", 32'(PxOut), 32'd9);
    step();
    check("line_hold", 32'(LineOut), 32'd1);
    ResetLine = 1;
    step();
    ResetLine = 0;
    check("line_clr", 32'(LineOut), 32'd0);
    check("line_clr_px", 32'(PxOut), 32'd9);

    // Address counters
    repeat (100) begin
      IncAddr0 = 1;
      step();
      IncAddr0 = 0;
      step();
    end
    check("a0_100", 32'(Addr0), 32'd100);
    check("a1_idle", 32'(Addr1), 32'd0);
    ResetAddr0 = 1;
    IncAddr1 = 1;
    step();
    ResetAddr0 = 0;
    IncAddr1 = 0;
    check("a0_clr_same", 32'(Addr0), 32'd0);
    check("a1_inc_same", 32'(Addr1), 32'd1);

    // Address full-range wrap
    IncAddr0 = 1;
    repeat (16383) step();
    IncAddr0 = 0;
    check("a0_max", 32'(Addr0), 32'd16383);
    IncAddr0 = 1;
    step();
    IncAddr0 = 0;
    check("a0_wrap", 32'(Addr0), 32'd0);
    check("a1_keep", 32'(Addr1), 32'd1);

    // Async reset mid-count
    IncLine = 1;
    repeat (5) step();
    check("line_5", 32'(LineOut), 32'd5);
    #2;
    reset = 1'b0;
    #1;
    check("line_async", 32'(LineOut), 32'd0);
    check("px_async", 32'(PxOut), 32'd0);
    check("a1_async", 32'(Addr1), 32'd0);
    step();
    check("line_held_rst", 32'(LineOut), 32'd0);
    reset = 1'b1;
    step();
    check("line_resume", 32'(LineOut), 32'd1);
    IncLine = 0;

    // Random strobes across an asynchronous reset
    IncPx = 1;
    IncAddr1 = 1;
    step();
    step();
    check("pre_rand_px", 32'(PxOut), 32'd2);
    strobes_rand();
    #3;
    reset = 1'b0;
    #1;
    check_all_zero("rand_rst");
    for (int i = 0; i < 3; i++) begin
      strobes_rand();
      step();
    end
    check_all_zero("rand_rst_hold");
    strobes_off();
    reset = 1'b1;
    step();
    step();
    check_all_zero("rand_rel_idle");
    check("px9_rand_rel", 32'(w_px9), 32'd0);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule

`default_nettype wire
